// File: rtl/pipelined_csel_sub32_if.sv
// Handshake and operand/result bundle for the pipelined 32-bit subtractor.
// The slave modport is the subtractor; the master modport is its user,
// which both sources operands and consumes results.
interface pipelined_csel_sub32_if;
    // operand side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    // result side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        of;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, of
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, of
    );
endinterface

// File: rtl/pipelined_csel_sub32.sv
// Two-stage 32-bit carry-select subtractor: diff = a - b - bin.
// Stage 1 resolves the low half and precomputes both upper-half candidates;
// stage 2 picks the candidate with the low-half carry and forms the flags.
// Subtraction is a + ~b + ~bin, so a carry out means "no borrow".
module pipelined_csel_sub32 (
    input logic                    clk,
    input logic                    rst_n,
    pipelined_csel_sub32_if.slave  bus
);

    // stage 1 state
    logic        s1_valid;
    logic [15:0] s1_lo;
    logic        s1_c16;
    logic [16:0] s1_u0;
    logic [16:0] s1_u1;
    logic        s1_a31;
    logic        s1_b31;

    // stage 2 state (drives the result side directly)
    logic        s2_valid;
    logic [31:0] s2_diff;
    logic        s2_bout;
    logic        s2_of;

    // combinational stage results
    logic [16:0] lo_sum;
    logic [16:0] u0_sum;
    logic [16:0] u1_sum;
    logic [16:0] sel;
    logic [31:0] diff_next;
    logic        bout_next;
    logic        of_next;

    logic in_xfer;
    logic s1_adv;
    logic out_xfer;

    assign s1_adv   = s1_valid && (!s2_valid || bus.out_ready);
    assign out_xfer = s2_valid && bus.out_ready;
    // in_ready may look through to out_ready; this is the only
    // combinational input-to-output path in the block.
    assign bus.in_ready = !s1_valid || s1_adv;
    assign in_xfer      = bus.in_valid && bus.in_ready;

    // Stage 1 arithmetic: low half with the borrow-in, both upper candidates.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        lo_sum = '0;
        u0_sum = '0;
        u1_sum = '0;
        lo_sum = {1'b0, bus.a[15:0]} + {1'b0, ~bus.b[15:0]} + {16'b0, ~bus.bin};
        u0_sum = {1'b0, bus.a[31:16]} + {1'b0, ~bus.b[31:16]};
        u1_sum = {1'b0, bus.a[31:16]} + {1'b0, ~bus.b[31:16]} + 17'd1;
    end

    // Stage 2 arithmetic: select the upper half by the low-half carry, not bin.
    always_comb begin
        sel       = s1_c16 ? s1_u1 : s1_u0;
        diff_next = {sel[15:0], s1_lo};
        bout_next = ~sel[16];
        of_next   = (s1_a31 != s1_b31) && (sel[15] != s1_a31);
    end

    // Stage 1 register: capture on input transfer, empty when it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, because the result outputs must read zero out of reset.
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c16   <= 1'b0;
            s1_u0    <= '0;
            s1_u1    <= '0;
            s1_a31   <= 1'b0;
            s1_b31   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so both stages sample pre-edge values in the same clock.
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_lo    <= lo_sum[15:0];
                s1_c16   <= lo_sum[16];
                s1_u0    <= u0_sum;
                s1_u1    <= u1_sum;
                s1_a31   <= bus.a[31];
                s1_b31   <= bus.b[31];
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 register: load on advance, drop valid after an unreplaced transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_diff  <= '0;
            s2_bout  <= 1'b0;
            s2_of    <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_valid <= 1'b1;
                s2_diff  <= diff_next;
                s2_bout  <= bout_next;
                s2_of    <= of_next;
            end else if (out_xfer) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.diff      = s2_diff;
    assign bus.bout      = s2_bout;
    assign bus.of        = s2_of;

endmodule
